// File: rtl/demux2_router.sv
// Buffered 1-to-2 word router: each destination has its own small FIFO, so
// a stalled consumer only blocks traffic addressed to it.

module demux2_router_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       ready,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign valid   = (count != '0);
    assign do_push = push & ~full;
    assign do_pop  = valid & ready;
    assign rdata   = valid ? mem[rptr] : '0;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

module demux2_router #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           a_data,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [WIDTH-1:0]           b_data,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [$clog2(DEPTH):0]     a_count,
    output logic [$clog2(DEPTH):0]     b_count
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic push_a;
    logic push_b;

    // Readiness looks only at registered occupancy, never at the consumer
    // ready lines, so a full FIFO refuses even in a cycle where it drains.
    assign in_ready = in_sel ? (b_count != CW'(DEPTH)) : (a_count != CW'(DEPTH));
    assign push_a   = in_valid & in_ready & ~in_sel;
    assign push_b   = in_valid & in_ready &  in_sel;

    demux2_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a),
        .wdata (in_data),
        .ready (a_ready),
        .rdata (a_data),
        .valid (a_valid),
        .count (a_count)
    );

    demux2_router_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b),
        .wdata (in_data),
        .ready (b_ready),
        .rdata (b_data),
        .valid (b_valid),
        .count (b_count)
    );
endmodule
